// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared FSM state type and timer sizing for the key pulse conditioner
package key_cond_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} key_state_t;
  function automatic int timer_w(int a, int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction
endpackage

// File: rtl/key_pulse_conditioner_if.sv
// key_pulse_conditioner_if: button-side inputs and pulse/level outputs of the conditioner
interface key_pulse_conditioner_if;
  logic btn_in;
  logic repeat_en;
  logic pulse;
  logic pressed;
  modport master (output btn_in, repeat_en, input pulse, pressed);
  modport slave (input btn_in, repeat_en, output pulse, pressed);
endinterface

// File: rtl/key_pulse_conditioner_sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous board input, active-low sync reset
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (!rst) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/key_pulse_conditioner.sv
// key_pulse_conditioner: debounced single-cycle press pulse with optional auto-repeat
module key_pulse_conditioner
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter bit ACTIVE_LOW_IN   = 1'b1
) (
  input logic clk,
  input logic rst,
  key_pulse_conditioner_if.slave kif
);
  localparam int TW = timer_w(DEBOUNCE_CYCLES, REPEAT_DELAY);
  localparam logic [TW-1:0] DB_LAST = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);
  key_state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic first_done, first_n, pulse_n, s, p, stay_held, fire;
  sync_2ff #(.RST_VAL(ACTIVE_LOW_IN)) u_sync (.clk(clk), .rst(rst), .d(kif.btn_in), .q(s));
  assign p = s ^ ACTIVE_LOW_IN;
  assign stay_held = state == HELD && state_n == HELD;
  assign fire = kif.repeat_en && timer == (first_done ? RP_LAST : RD_LAST);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = p ? PRESS_DB : IDLE;
      PRESS_DB:   state_n = !p ? IDLE : (timer == DB_LAST ? HELD : PRESS_DB);
      HELD:       state_n = p ? HELD : RELEASE_DB;
      RELEASE_DB: state_n = p ? HELD : (timer == DB_LAST ? IDLE : RELEASE_DB);
      default:    state_n = IDLE;
    endcase
  end
  // repeat timer only runs while staying in HELD; dropping repeat_en restarts from REPEAT_DELAY
  always_comb begin
    timer_n = (state_n != state || state == IDLE) ? '0 : timer + 1'b1;
    first_n = 1'b0;
    pulse_n = state == PRESS_DB && state_n == HELD;
    if (stay_held) begin
      timer_n = (!kif.repeat_en || fire) ? '0 : timer + 1'b1;
      first_n = kif.repeat_en && (first_done || fire);
      pulse_n = fire;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state       <= IDLE;
      timer       <= '0;
      first_done  <= 1'b0;
      kif.pulse   <= 1'b0;
      kif.pressed <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      first_done  <= first_n;
      kif.pulse   <= pulse_n;
      kif.pressed <= state_n == HELD || state_n == RELEASE_DB;
    end
endmodule
